// File: rtl/pooling_window_feeder_pkg.sv
// Shared definitions for the pooling window feeder: FSM states and width helpers.
package pooling_window_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int KERNEL_W = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pooling_window_feeder_band_buffer.sv
// Band buffer: simple dual-port RAM holding KERNEL rows, registered read port.
module pooling_window_feeder_band_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 192,
  parameter int AW         = 8
) (
  input  logic                  CLK,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read data is held while rd_en_i is low so a stalled word is not lost.
  always_ff @(posedge CLK) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pooling_window_feeder.sv
// Buffers KERNEL rows of a raster feature map and re-emits each KxK window as a burst.
// state | meaning: IDLE wait GO | FILL load band | EMIT stream windows | DRAIN discard rest, then DONE
module pooling_window_feeder
  import pooling_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WIDTH  = 64,
  parameter int MAX_HEIGHT = 64,
  parameter int MAX_KERNEL = 3
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              INIT_I,
  output logic                              READY_O,
  input  logic                              GO_I,
  input  logic [clog2(MAX_WIDTH+1)-1:0]     CFG_WIDTH_I,
  input  logic [clog2(MAX_HEIGHT+1)-1:0]    CFG_HEIGHT_I,
  input  logic [KERNEL_W-1:0]               CFG_KERNEL_I,
  output logic                              IN_READY_O,
  input  logic [DATA_WIDTH-1:0]             IN_DATA_I,
  input  logic                              IN_VALID_I,
  input  logic                              IN_LAST_I,
  output logic [DATA_WIDTH-1:0]             OUT_DATA_O,
  output logic                              OUT_VALID_O,
  input  logic                              OUT_READY_I,
  output logic                              OUT_LAST_O,
  output logic                              DONE_O,
  output logic                              ERROR_O
);

  localparam int WW    = clog2(MAX_WIDTH + 1);
  localparam int HW    = clog2(MAX_HEIGHT + 1);
  localparam int DEPTH = MAX_KERNEL * MAX_WIDTH;
  localparam int AW    = clog2(DEPTH);

  state_e                state_q, state_d;
  logic [WW-1:0]         w_q, w_d, col_q, col_d, c0_q, c0_d;
  logic [HW-1:0]         h_q, h_d, row_q, row_d;
  logic [KERNEL_W-1:0]   k_q, k_d, brow_q, brow_d, er_q, er_d, ec_q, ec_d;
  logic                  last_seen_q, last_seen_d, iss_done_q, iss_done_d;
  logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, rd_data;
  logic                  err_q, err_d, done_q, done_d, ready_q, ready_d;

  logic [WW-1:0]       w_m1, k_w, c0_nx;
  logic [WW:0]         c0_end;
  logic [HW-1:0]       h_m1, k_h, rows_left;
  logic [KERNEL_W-1:0] k_m1;
  logic                eol, final_elem, band_end, in_rdy, in_acc, load, issue;
  logic                win_last, last_win, cfg_bad, wr_en;
  logic [AW-1:0]       wr_addr, rd_addr;

  assign w_m1       = w_q - WW'(1);
  assign h_m1       = h_q - HW'(1);
  assign k_m1       = k_q - KERNEL_W'(1);
  assign k_w        = WW'(k_q);
  assign k_h        = HW'(k_q);
  assign rows_left  = h_q - row_q;
  assign eol        = (col_q == w_m1);
  assign final_elem = eol && (row_q == h_m1);
  assign band_end   = eol && (brow_q == k_m1);
  assign in_rdy     = (state_q == ST_FILL) || ((state_q == ST_DRAIN) && !last_seen_q);
  assign in_acc     = IN_VALID_I && in_rdy;
  assign load       = rd_valid_q && (!out_valid_q || OUT_READY_I);
  assign issue      = (state_q == ST_EMIT) && !iss_done_q && (!rd_valid_q || load);
  assign win_last   = (er_q == k_m1) && (ec_q == k_m1);
  assign c0_nx      = c0_q + k_w;
  assign c0_end     = {1'b0, c0_nx} + {1'b0, k_w};
  // A window is the last of the band when the next one would run past column W-1.
  assign last_win   = c0_end > {1'b0, w_q};
  assign cfg_bad    = (CFG_WIDTH_I == '0) || (CFG_WIDTH_I > WW'(MAX_WIDTH)) ||
                      (CFG_HEIGHT_I == '0) || (CFG_HEIGHT_I > HW'(MAX_HEIGHT)) ||
                      (CFG_KERNEL_I == '0) || (CFG_KERNEL_I > KERNEL_W'(MAX_KERNEL));

  assign wr_en   = in_acc && (state_q == ST_FILL);
  assign wr_addr = AW'(brow_q) * AW'(MAX_WIDTH) + AW'(col_q);
  assign rd_addr = AW'(er_q) * AW'(MAX_WIDTH) + AW'(c0_q) + AW'(ec_q);

  pooling_window_feeder_band_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_band_buffer (
    .CLK       (CLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (IN_DATA_I),
    .rd_en_i   (issue),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    h_d         = h_q;
    k_d         = k_q;
    col_d       = col_q;
    row_d       = row_q;
    brow_d      = brow_q;
    c0_d        = c0_q;
    er_d        = er_q;
    ec_d        = ec_q;
    last_seen_d = last_seen_q;
    iss_done_d  = iss_done_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    done_d      = 1'b0;
    ready_d     = 1'b1;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      out_last_d  = rd_last_q;
    end else if (OUT_READY_I) begin
      out_valid_d = 1'b0;
    end

    if (issue) begin
      rd_valid_d = 1'b1;
      rd_last_d  = win_last;
    end else if (load) begin
      rd_valid_d = 1'b0;
    end

    // Raster position tracking; row saturates at H.
    if (in_acc) begin
      if (eol) begin
        col_d  = '0;
        brow_d = (brow_q == k_m1) ? '0 : brow_q + KERNEL_W'(1);
        if (row_q != h_q) row_d = row_q + HW'(1);
      end else begin
        col_d = col_q + WW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (GO_I) begin
          w_d         = CFG_WIDTH_I;
          h_d         = CFG_HEIGHT_I;
          k_d         = CFG_KERNEL_I;
          col_d       = '0;
          row_d       = '0;
          brow_d      = '0;
          c0_d        = '0;
          er_d        = '0;
          ec_d        = '0;
          last_seen_d = 1'b0;
          iss_done_d  = 1'b0;
          if (cfg_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            state_d = (CFG_HEIGHT_I < HW'(CFG_KERNEL_I)) ? ST_DRAIN : ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (in_acc) begin
          if (IN_LAST_I && !final_elem) begin
            err_d       = 1'b1;
            last_seen_d = 1'b1;
            state_d     = ST_DRAIN;
          end else begin
            if (final_elem) begin
              last_seen_d = 1'b1;
              if (!IN_LAST_I) err_d = 1'b1;
            end
            if (band_end) begin
              c0_d       = '0;
              er_d       = '0;
              ec_d       = '0;
              iss_done_d = 1'b0;
              if (w_q >= k_w)          state_d = ST_EMIT;
              else if (rows_left > k_h) state_d = ST_FILL;
              else                      state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_EMIT: begin
        if (issue) begin
          if (ec_q == k_m1) begin
            ec_d = '0;
            if (er_q == k_m1) begin
              er_d = '0;
              c0_d = c0_nx;
              if (last_win) iss_done_d = 1'b1;
            end else begin
              er_d = er_q + KERNEL_W'(1);
            end
          end else begin
            ec_d = ec_q + KERNEL_W'(1);
          end
        end
        if (iss_done_q && !rd_valid_q) begin
          state_d = (rows_left >= k_h) ? ST_FILL : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_acc && (IN_LAST_I || final_elem)) begin
          last_seen_d = 1'b1;
          if (IN_LAST_I != final_elem) err_d = 1'b1;
        end
        if (last_seen_q && !out_valid_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // INIT behaves exactly like reset; pending output is dropped.
    if (INIT_I) begin
      state_d     = ST_IDLE;
      col_d       = '0;
      row_d       = '0;
      brow_d      = '0;
      c0_d        = '0;
      er_d        = '0;
      ec_d        = '0;
      last_seen_d = 1'b0;
      iss_done_d  = 1'b0;
      rd_valid_d  = 1'b0;
      rd_last_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
      err_d       = 1'b0;
      done_d      = 1'b0;
      ready_d     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      k_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      brow_q      <= '0;
      c0_q        <= '0;
      er_q        <= '0;
      ec_q        <= '0;
      last_seen_q <= 1'b0;
      iss_done_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      k_q         <= k_d;
      col_q       <= col_d;
      row_q       <= row_d;
      brow_q      <= brow_d;
      c0_q        <= c0_d;
      er_q        <= er_d;
      ec_q        <= ec_d;
      last_seen_q <= last_seen_d;
      iss_done_q  <= iss_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign READY_O     = ready_q;
  assign IN_READY_O  = in_rdy;
  assign OUT_DATA_O  = out_data_q;
  assign OUT_VALID_O = out_valid_q;
  assign OUT_LAST_O  = out_last_q;
  assign DONE_O      = done_q;
  assign ERROR_O     = err_q;

endmodule

// File: tb/tb_pooling_window_feeder.sv
// Directed bench for pooling_window_feeder: window-order model plus literal sequences.
module tb_pooling_window_feeder;

  localparam int DW = 32;
  localparam int MW = 64;
  localparam int MH = 64;
  localparam int MK = 3;
  localparam int WW = $clog2(MW + 1);
  localparam int HW = $clog2(MH + 1);

  logic          CLK = 1'b0;
  logic          RESET_N, INIT_I, GO_I;
  logic [WW-1:0] CFG_WIDTH_I;
  logic [HW-1:0] CFG_HEIGHT_I;
  logic [1:0]    CFG_KERNEL_I;
  logic [DW-1:0] IN_DATA_I, OUT_DATA_O;
  logic          IN_VALID_I, IN_LAST_I, IN_READY_O, READY_O;
  logic          OUT_VALID_O, OUT_READY_I, OUT_LAST_O, DONE_O, ERROR_O;

  pooling_window_feeder #(
    .DATA_WIDTH (DW), .MAX_WIDTH (MW), .MAX_HEIGHT (MH), .MAX_KERNEL (MK)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .INIT_I       (INIT_I),
    .READY_O      (READY_O),
    .GO_I         (GO_I),
    .CFG_WIDTH_I  (CFG_WIDTH_I),
    .CFG_HEIGHT_I (CFG_HEIGHT_I),
    .CFG_KERNEL_I (CFG_KERNEL_I),
    .IN_READY_O   (IN_READY_O),
    .IN_DATA_I    (IN_DATA_I),
    .IN_VALID_I   (IN_VALID_I),
    .IN_LAST_I    (IN_LAST_I),
    .OUT_DATA_O   (OUT_DATA_O),
    .OUT_VALID_O  (OUT_VALID_O),
    .OUT_READY_I  (OUT_READY_I),
    .OUT_LAST_O   (OUT_LAST_O),
    .DONE_O       (DONE_O),
    .ERROR_O      (ERROR_O)
  );

  always #5 CLK = ~CLK;

  int            n_vec = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  int            rdy_mode = 0;
  bit            chk_en = 1'b0;
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  logic [DW-1:0] got_q[$];
  int            lit_q[$];
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected stream: every full KxK window of every full band, row-major inside the window.
  task automatic model(input int w, input int h, input int k, input int last_at);
    exp_d.delete();
    exp_l.delete();
    if (last_at >= 0) return;
    for (int b = 0; b < h / k; b++)
      for (int c0 = 0; c0 + k <= w; c0 += k)
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++) begin
            exp_d.push_back(DW'((b * k + r) * w + c0 + c));
            exp_l.push_back((r == k - 1) && (c == k - 1));
          end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      if (pv && !pr) begin
        check("hold_valid", 64'(OUT_VALID_O), 64'(1));
        check("hold_data", 64'(OUT_DATA_O), 64'(pd));
        check("hold_last", 64'(OUT_LAST_O), 64'(pl));
      end
      if (OUT_VALID_O && OUT_READY_I) begin
        got_q.push_back(OUT_DATA_O);
        if (exp_d.size() == 0) check("out_overrun", 64'(exp_d.size()), 64'(1));
        else begin
          check("out_data", 64'(OUT_DATA_O), 64'(exp_d.pop_front()));
          check("out_last", 64'(OUT_LAST_O), 64'(exp_l.pop_front()));
        end
      end
      if (DONE_O) begin
        check("done_with_pending", 64'(exp_d.size()), 64'(0));
        done_cnt++;
      end
    end
    pv = OUT_VALID_O;
    pr = OUT_READY_I;
    pd = OUT_DATA_O;
    pl = OUT_LAST_O;
  end

  initial begin
    OUT_READY_I = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       OUT_READY_I = 1'b1;
        1:       OUT_READY_I = 1'($urandom_range(0, 1));
        default: OUT_READY_I = 1'b0;
      endcase
    end
  end

  task automatic pulse_go(input int w, input int h, input int k);
    CFG_WIDTH_I  = WW'(w);
    CFG_HEIGHT_I = HW'(h);
    CFG_KERNEL_I = 2'(k);
    GO_I = 1'b1;
    @(posedge CLK);
    #1;
    GO_I = 1'b0;
  endtask

  task automatic send(input int d, input bit last, input bit gaps);
    bit acc;
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    IN_VALID_I = 1'b1;
    IN_DATA_I  = DW'(d);
    IN_LAST_I  = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 3000) begin
      @(negedge CLK);
      acc = IN_READY_O;
      @(posedge CLK);
      #1;
      n++;
    end
    IN_VALID_I = 1'b0;
    IN_LAST_I  = 1'b0;
    if (!acc) check("in_accept_timeout", 64'(acc), 64'(1));
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 3000) begin @(posedge CLK); #1; n++; end
    check("done_pulse", 64'(done_cnt - start), 64'(1));
  endtask

  task automatic run_map(input int w, input int h, input int k, input int last_at,
                         input bit gaps, input bit exp_err);
    int start;
    got_q.delete();
    model(w, h, k, last_at);
    pulse_go(w, h, k);
    check("err_clear_on_go", 64'(ERROR_O), 64'(0));
    start = done_cnt;
    for (int i = 0; i < w * h; i++) begin
      if (last_at >= 0 && i > last_at) break;
      send(i, (i == last_at) || (i == w * h - 1), gaps);
    end
    wait_done(start);
    check("error_flag", 64'(ERROR_O), 64'(exp_err));
    check("in_ready_idle", 64'(IN_READY_O), 64'(0));
    check("all_windows_out", 64'(exp_d.size()), 64'(0));
  endtask

  task automatic cmp_lit(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++)
      if (i < got_q.size()) check(tag, 64'(got_q[i]), 64'(lit_q[i]));
  endtask

  initial begin
    int start, n;
    RESET_N = 1'b0; INIT_I = 1'b0; GO_I = 1'b0;
    CFG_WIDTH_I = '0; CFG_HEIGHT_I = '0; CFG_KERNEL_I = '0;
    IN_DATA_I = '0; IN_VALID_I = 1'b0; IN_LAST_I = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ready", 64'(READY_O), 64'(0));
    check("rst_out_valid", 64'(OUT_VALID_O), 64'(0));
    check("rst_out_data", 64'(OUT_DATA_O), 64'(0));
    check("rst_out_last", 64'(OUT_LAST_O), 64'(0));
    check("rst_in_ready", 64'(IN_READY_O), 64'(0));
    check("rst_done", 64'(DONE_O), 64'(0));
    check("rst_error", 64'(ERROR_O), 64'(0));
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("ready_after_reset", 64'(READY_O), 64'(1));
    chk_en = 1'b1;

    lit_q = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    run_map(4, 4, 2, -1, 1'b0, 1'b0);
    cmp_lit("t1_seq");

    rdy_mode = 1;
    run_map(4, 4, 2, -1, 1'b1, 1'b0);
    cmp_lit("t2_seq");
    rdy_mode = 0;

    lit_q = '{0, 1, 5, 6, 2, 3, 7, 8, 10, 11, 15, 16, 12, 13, 17, 18};
    run_map(5, 5, 2, -1, 1'b0, 1'b0);
    cmp_lit("t3_seq");

    lit_q = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 3, 4, 5, 9, 10, 11, 15, 16, 17};
    run_map(6, 3, 3, -1, 1'b0, 1'b0);
    cmp_lit("t4_seq");

    run_map(4, 4, 2, 5, 1'b0, 1'b1);
    check("t5_no_output", 64'(got_q.size()), 64'(0));

    lit_q = '{0, 1, 2, 3, 4, 5};
    run_map(3, 2, 1, -1, 1'b0, 1'b0);
    cmp_lit("k1_seq");

    run_map(2, 4, 3, -1, 1'b0, 1'b0);
    check("narrow_no_output", 64'(got_q.size()), 64'(0));

    start = done_cnt;
    pulse_go(4, 4, 0);
    check("bad_cfg_error", 64'(ERROR_O), 64'(1));
    wait_done(start);
    check("bad_cfg_idle", 64'(IN_READY_O), 64'(0));

    rdy_mode = 2;
    model(4, 4, 2, -1);
    pulse_go(4, 4, 2);
    for (int i = 0; i < 8; i++) send(i, 1'b0, 1'b0);
    n = 0;
    while (!OUT_VALID_O && n < 20) begin @(posedge CLK); #1; n++; end
    check("t6_valid_before_init", 64'(OUT_VALID_O), 64'(1));
    repeat (2) begin @(posedge CLK); #1; end
    chk_en = 1'b0;
    INIT_I = 1'b1;
    @(posedge CLK); #1;
    check("init_out_valid", 64'(OUT_VALID_O), 64'(0));
    check("init_ready", 64'(READY_O), 64'(0));
    check("init_in_ready", 64'(IN_READY_O), 64'(0));
    INIT_I = 1'b0;
    exp_d.delete();
    exp_l.delete();
    rdy_mode = 0;
    @(posedge CLK); #1;
    check("ready_after_init", 64'(READY_O), 64'(1));
    chk_en = 1'b1;
    lit_q = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    run_map(4, 4, 2, -1, 1'b0, 1'b0);
    cmp_lit("t6_rerun_seq");

    repeat (4) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
